digit_entry_buffer: RTL and testbench

Consumes the one-hot digit-key vector and its single-cycle "new key" pulse from the key-valid pulse stage directly upstream. Turns those into a multi-digit decimal entry for the keypad calculator datapath.
Encodes each accepted key to BCD and shifts it into an NDIG-digit entry register (shown live on the 7-segment display). On enter, runs a sequential BCD-to-binary conversion and presents the committed binary operand with a one-cycle valid pulse.

---
 rtl/digit_entry_buffer.sv | 129 ++++++++++++
 tb/tb_digit_entry_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: turns debounced keypad digit presses into a multi-digit
// BCD entry, and on enter converts it to a binary operand.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   keys          one-hot digit key vector (bit i = key "i")
//   num_valid     one-cycle pulse: new key pressed
//   clr           one-cycle pulse: discard the entry
//   enter         one-cycle pulse: commit the entry
//   digits        BCD entry register, [3:0] = most recent digit
//   digit_cnt     number of digits entered, 0..NDIG
//   overflow      sticky: a digit was dropped because the buffer was full
//   busy          high while converting
//   value         last committed binary value
//   value_valid   one-cycle pulse when value updates
module digit_entry_buffer #(
    parameter int unsigned NDIG = 4,
    parameter int unsigned VW   = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          keys,
    input  logic                num_valid,
    input  logic                clr,
    input  logic                enter,
    output logic [4*NDIG-1:0]   digits,
    output logic [2:0]          digit_cnt,
    output logic                overflow,
    output logic                busy,
    output logic [VW-1:0]       value,
    output logic                value_valid
);

    localparam int unsigned DW = 4 * NDIG;
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CW = 3;
    localparam int unsigned KW = 10;

    typedef enum logic {
        ENTRY = 1'b0,
        CONV  = 1'b1
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_digits;
    logic [CW-1:0]   r_cnt;
    logic            r_overflow;
    logic [VW-1:0]   r_acc;
    logic [IW-1:0]   r_idx;
    logic [VW-1:0]   r_value;
    logic            r_value_valid;

    logic [3:0]      w_bcd;
    logic            w_key_any;
    logic [3:0]      w_cur_digit;
    logic [VW-1:0]   w_acc_next;

    // Highest set key bit wins if several keys are held.
    always_comb begin
        w_bcd     = 4'd0;
        w_key_any = |keys;
        for (int i = 0; i < int'(KW); i++) begin
            if (keys[i]) begin
                w_bcd = 4'(i);
            end
        end
    end

    // Digit being folded in this conversion step, most significant first.
    assign w_cur_digit = r_digits[{r_idx, 2'b00} +: 4];
    assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + VW'(w_cur_digit);

    // Entry/conversion state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ENTRY;
            r_digits      <= '0;
            r_cnt         <= '0;
            r_overflow    <= 1'b0;
            r_acc         <= '0;
            r_idx         <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
        end else begin
            r_value_valid <= 1'b0;
            case (r_state)
                ENTRY: begin
                    if (clr) begin
                        r_digits   <= '0;
                        r_cnt      <= '0;
                        r_overflow <= 1'b0;
                    end else if (enter) begin
                        r_state <= CONV;
                        r_idx   <= IW'(NDIG - 1);
                        r_acc   <= '0;
                    end else if (num_valid && w_key_any) begin
                        if (r_cnt < CW'(NDIG)) begin
                            r_digits <= {r_digits[DW-5:0], w_bcd};
                            r_cnt    <= r_cnt + 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx - 1'b1;
                    if (r_idx == '0) begin
                        r_value       <= w_acc_next;
                        r_value_valid <= 1'b1;
                        r_digits      <= '0;
                        r_cnt         <= '0;
                        r_overflow    <= 1'b0;
                        r_state       <= ENTRY;
                    end
                end
                default: r_state <= ENTRY;
            endcase
        end
    end

    assign digits      = r_digits;
    assign digit_cnt   = r_cnt;
    assign overflow    = r_overflow;
    assign busy        = (r_state == CONV);
    assign value       = r_value;
    assign value_valid = r_value_valid;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Self-checking bench for digit_entry_buffer: directed scenarios plus random
// key/clear/enter traffic compared each cycle against a queue-based model.
module tb_digit_entry_buffer;

    localparam int NDIG = 4;
    localparam int VW   = 14;

    logic              clk;
    logic              rst_n;
    logic [9:0]        keys;
    logic              num_valid;
    logic              clr;
    logic              enter;
    logic [4*NDIG-1:0] digits;
    logic [2:0]        digit_cnt;
    logic              overflow;
    logic              busy;
    logic [VW-1:0]     value;
    logic              value_valid;

    digit_entry_buffer #(.NDIG(NDIG), .VW(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keys        (keys),
        .num_valid   (num_valid),
        .clr         (clr),
        .enter       (enter),
        .digits      (digits),
        .digit_cnt   (digit_cnt),
        .overflow    (overflow),
        .busy        (busy),
        .value       (value),
        .value_valid (value_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: entered digits oldest-first, plus conversion countdown.
    int m_q[$];
    int m_ovf;
    int m_value;
    int m_vv;
    int m_conv_left;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int model_digits();
        int r = 0;
        foreach (m_q[i]) r = (r << 4) | m_q[i];
        return r;
    endfunction

    function automatic int model_decimal();
        int r = 0;
        foreach (m_q[i]) r = r * 10 + m_q[i];
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf       = 0;
        m_value     = 0;
        m_vv        = 0;
        m_conv_left = 0;
    endtask

    task automatic model_edge(input logic [9:0] k, input logic nv,
                              input logic c, input logic e);
        int d;
        m_vv = 0;
        if (m_conv_left > 0) begin
            m_conv_left--;
            if (m_conv_left == 0) begin
                m_value = model_decimal();
                m_vv    = 1;
                m_q.delete();
                m_ovf   = 0;
            end
        end else if (c) begin
            m_q.delete();
            m_ovf = 0;
        end else if (e) begin
            m_conv_left = NDIG;
        end else if (nv && k != 10'd0) begin
            d = 0;
            for (int i = 0; i < 10; i++) if (k[i]) d = i;
            if (m_q.size() < NDIG) m_q.push_back(d);
            else m_ovf = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".digits"},   int'(digits),      model_digits());
        check({tag, ".cnt"},      int'(digit_cnt),   m_q.size());
        check({tag, ".ovf"},      int'(overflow),    m_ovf);
        check({tag, ".busy"},     int'(busy),        (m_conv_left > 0) ? 1 : 0);
        check({tag, ".value"},    int'(value),       m_value);
        check({tag, ".vv"},       int'(value_valid), m_vv);
    endtask

    // One clock: drive inputs, clock edge, update model, check #1 after edge.
    task automatic step(input string tag, input logic [9:0] k, input logic nv,
                        input logic c, input logic e);
        keys = k; num_valid = nv; clr = c; enter = e;
        @(posedge clk);
        model_edge(k, nv, c, e);
        #1;
        keys = '0; num_valid = 0; clr = 0; enter = 0;
        check_all(tag);
    endtask

    task automatic press(input string tag, input int d);
        logic [9:0] k;
        k = 10'(1 << d);
        step(tag, k, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all({tag, ".held"});
    endtask

    initial begin
        logic [9:0] k;
        logic       nv, c, e;
        int         r;

        rst_n = 1'b0; keys = '0; num_valid = 0; clr = 0; enter = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        idle("idle", 2);

        // 1,2,3 then enter -> 123
        press("k1", 1); press("k2", 2); press("k3", 3);
        check("d0123", int'(digits), 32'h0123);
        step("ent123", 10'd0, 1'b0, 1'b0, 1'b1);
        idle("conv123", 5);
        check("val123", int'(value), 123);

        // Overflow: 9,9,9,9,7 then enter -> 9999
        press("n9a", 9); press("n9b", 9); press("n9c", 9); press("n9d", 9);
        press("n7", 7);
        check("d9999", int'(digits), 32'h9999);
        check("ovf9999", int'(overflow), 1);
        step("ent9999", 10'd0, 1'b0, 1'b0, 1'b1);
        idle("conv9999", 5);
        check("val9999", int'(value), 9999);

        // Zero key vector ignored; multi-key picks highest (5)
        step("kzero", 10'd0, 1'b1, 1'b0, 1'b0);
        step("kmulti", 10'b0000100100, 1'b1, 1'b0, 1'b0);
        check("d5", int'(digits), 5);

        // clr beats enter and num_valid
        step("clr0", 10'd0, 1'b0, 1'b1, 1'b0);
        press("n4", 4); press("n2", 2);
        step("clrwins", 10'b0000001000, 1'b1, 1'b1, 1'b1);
        idle("clridle", 2);
        check("valkept", int'(value), 9999);

        // Inputs during conversion of 0007 are dropped
        press("n7b", 7);
        step("ent7", 10'd0, 1'b0, 1'b0, 1'b1);
        press("cnv_k", 3);
        step("cnv_e", 10'd0, 1'b0, 1'b0, 1'b1);
        step("cnv_c", 10'd0, 1'b0, 1'b1, 1'b0);
        idle("conv7", 3);
        check("val7", int'(value), 7);

        // Empty enter converts to 0
        step("ent0", 10'd0, 1'b0, 1'b0, 1'b1);
        idle("conv0", 5);

        // Reset in the middle of a conversion
        press("r8", 8); press("r6", 6);
        step("entr", 10'd0, 1'b0, 1'b0, 1'b1);
        idle("convr", 1);
        async_reset("midconv");
        idle("postrst", 6);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      k = 10'd0;
            else if (r < 7) k = 10'(1 << $urandom_range(0, 9));
            else            k = 10'($urandom);
            nv = ($urandom_range(0, 99) < 50);
            c  = ($urandom_range(0, 99) < 4);
            e  = ($urandom_range(0, 99) < 10);
            step("rand", k, nv, c, e);
        end
        idle("final", 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
